macarray_out_writer: RTL and testbench
======================================

# macarray_out_writer

- Downstream writeback stage of `macarray`.
- Accepts the row-major stream of 16-bit MAC results over a valid/ready handshake.
- Packs results into 64-bit words, four 16-bit lanes per word, and writes them to the 16×64 output SRAM through `EN_O`/`RW_O`/`ADDR_O`/`WDATA_O`.
- Signals completion with a one-cycle `DONE` pulse; supports result matrices up to 8×8 (M rows × T columns).

## Interface
No parameters; geometry fixed at 8×8 results, 16 output words.
- `CLK`  in  1  single clock, rising edge.
- `RSTN`  in  1  reset, asynchronous, active-low.
- `MNT`  in  12  `[11:8]`=M, `[7:4]`=N (unused), `[3:0]`=T; sampled only on accepted `START`.
- `START`  in  1  begin job; accepted only in IDLE.
- `RES_VALID`  in  1  `RES_DATA` valid.
- `RES_READY`  out  1  block can accept a result this cycle.
- `RES_DATA`  in  16  result, row-major order.
- `EN_O`  out  1  output SRAM enable.
- `RW_O`  out  1  1 = write (only meaningful with `EN_O`=1), else 0.
- `ADDR_O`  out  4  output word address.
- `WDATA_O`  out  64  write data.
- `BUSY`  out  1  high whenever state ≠ IDLE.
- `DONE`  out  1  one-cycle completion pulse.

## Operation
**Reset values**
- `RSTN` low forces state IDLE.
- All outputs drive 0: `EN_O`, `RW_O`, `ADDR_O`, `WDATA_O`, `RES_READY`, `BUSY`, `DONE`.
- Counters and pack register clear to 0.
- Reset mid-job abandons the job; no partial write completes after reset.

**Geometry latch**
- On `START` in IDLE: latch Mq=min(M,8), Tq=min(T,8).
- If Mq=0 or Tq=0, no results are accepted; DONE follows (after CLEAR if compiled in).

**Address map**
- Result (r,c) goes to word 2r + c[2], lane c[1:0], bits `[16*c[1:0]+15 : 16*c[1:0]]`.
- Lanes not written in a word are 0.
- Words for rows ≥ Mq are never written, except by CLEAR.

**States**
- IDLE: wait for `START`.
  - → CLEAR if `MACOUT_CLEAR_EN` is defined.
  - Otherwise → COLLECT, or → FINISH on the zero-size case.
- CLEAR: 16 write cycles, addresses 0..15, `WDATA_O`=0.
  - → COLLECT, or → FINISH on the zero-size case.
- COLLECT: `RES_READY`=1.
  - On `RES_VALID`&`RES_READY`, store `RES_DATA` into lane c[1:0] of the pack register.
  - If c[1:0]==3 or c==Tq-1 (word complete) → WRITE; otherwise c++ and stay.
- WRITE: one cycle with `EN_O`=1, `RW_O`=1, `ADDR_O`=2r+c[2], `WDATA_O`=pack; `RES_READY`=0.
  - Clear the pack register and advance: c++, or c=0 and r++ if c==Tq-1.
  - If the last result (r==Mq-1, c==Tq-1) was written → FINISH; else → COLLECT.
- FINISH: `DONE`=1 for one cycle → IDLE.

**Rules**
- `START` while `BUSY` is ignored.
- Extra `RES_VALID` after the last result is not accepted (`RES_READY`=0 outside COLLECT).
- Values presented while `RES_READY`=0 are ignored; the source holds `RES_DATA` until accepted.

## Timing
**Registered outputs**
- All outputs are registered.
- `EN_O`/`RW_O`/`ADDR_O`/`WDATA_O` are valid in the single WRITE cycle, which immediately follows the accepting edge.
- `RES_READY` is high in COLLECT from its first cycle.
- Outside write cycles, `EN_O`=0 and `RW_O`=0; `ADDR_O` and `WDATA_O` hold their last values.

**Latency and throughput**
- Full word: 4 accepts + 1 write = 5 cycles. Partial word (Tq not a multiple of 4): Tq mod 4 accepts + 1 write.
- `START` edge → first cycle of `RES_READY`=1: 1 cycle (no CLEAR) or 17 cycles (with CLEAR).
- Last WRITE cycle → `DONE` high in the next cycle; `BUSY` drops together with `DONE` low, i.e. one cycle after DONE.

## Configuration
- `MACOUT_CLEAR_EN` defined:
  - CLEAR state compiled in; all 16 words are zeroed before collection.
  - Unused rows read back as 0.
- `MACOUT_CLEAR_EN` undefined:
  - No CLEAR state; IDLE → COLLECT directly.
  - Only words 0..2·Mq-1 (covering written rows) are touched; other words keep stale contents.

## Test plan
- **Reset check:** assert `RSTN`=0 mid-COLLECT → all outputs 0 asynchronously. After release, `START` begins a clean job with no write to a stale address.
- **Partial words:** M=2,T=3, results 1..6 back-to-back.
  - Writes addr0=`0x0000_0003_0002_0001` and addr2=`0x0000_0006_0005_0004`, each a one-cycle `EN_O`/`RW_O`=1.
  - `DONE` one cycle after the second write.
- **Full row:** M=1,T=8, results `0x0011`..`0x0018`.
  - addr0=`0x0014_0013_0012_0011`, addr1=`0x0018_0017_0016_0015`.
  - `RES_READY` low exactly during each write cycle.
- **Backpressure and source stalls:** M=1,T=4, `RES_VALID` toggled 1,0,1,0…
  - Only valid cycles are captured; the single write is to addr0 with lanes in order.
  - A second `START` during the job is ignored.
- **Clamp and zero size:** MNT=`0xF4F` (M,T clamp to 8) → 16 writes, addr 0..15 ascending, then `DONE`. MNT=`0x040` (M=0) → no result accepted, `DONE` pulse.
- **`MACOUT_CLEAR_EN` defined:** M=1,T=1 → 16 zero writes to addr 0..15, then the addr0 write, then `DONE`; the first `RES_READY` appears 17 cycles after `START`.

Source files
------------

// File: rtl/macarray_out_writer.sv
// Writeback stage for macarray: packs the row-major 16-bit result stream into 64-bit words for the 16x64 output SRAM.
// Define MACOUT_CLEAR_EN to zero all 16 output words before each job.
module macarray_out_writer (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [11:0] MNT,
    input  logic        START,
    input  logic        RES_VALID,
    output logic        RES_READY,
    input  logic [15:0] RES_DATA,
    output logic        EN_O,
    output logic        RW_O,
    output logic [3:0]  ADDR_O,
    output logic [63:0] WDATA_O,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        COLLECT = 3'd2,
        WRITE   = 3'd3,
        FINISH  = 3'd4
    } state_t;

    state_t      state, state_d;
    logic [3:0]  mq, mq_d, tq, tq_d;
    logic [3:0]  r, r_d;
    logic [2:0]  c, c_d;
    logic [63:0] pack, pack_d, merged;
    logic        wr_d;
    logic [3:0]  addr_d;
    logic [63:0] wdata_d;
    logic [3:0]  m_clamped, t_clamped;
    logic        last_col, last_row, word_done, accept;
`ifdef MACOUT_CLEAR_EN
    logic [4:0]  clr_cnt, clr_cnt_d;
`endif

    // N is carried in MNT but plays no part in writeback.
    logic unused_n;
    assign unused_n = ^MNT[7:4];

    function automatic logic [3:0] clamp8(input logic [3:0] v);
        return (v > 4'd8) ? 4'd8 : v;
    endfunction

    function automatic logic [63:0] put_lane(input logic [63:0] word, input logic [1:0] lane,
                                             input logic [15:0] data);
        logic [63:0] w;
        w = word;
        case (lane)
            2'd0: w[15:0]  = data;
            2'd1: w[31:16] = data;
            2'd2: w[47:32] = data;
            default: w[63:48] = data;
        endcase
        return w;
    endfunction

    assign m_clamped = clamp8(MNT[11:8]);
    assign t_clamped = clamp8(MNT[3:0]);
    assign last_col  = ({1'b0, c} == (tq - 4'd1));
    assign last_row  = (r == (mq - 4'd1));
    assign word_done = (c[1:0] == 2'd3) || last_col;
    assign accept    = (state == COLLECT) && RES_VALID && RES_READY;
    assign merged    = put_lane(pack, c[1:0], RES_DATA);

    always_comb begin
        state_d = state;
        mq_d    = mq;
        tq_d    = tq;
        r_d     = r;
        c_d     = c;
        pack_d  = pack;
        wr_d    = 1'b0;
        addr_d  = ADDR_O;
        wdata_d = WDATA_O;
`ifdef MACOUT_CLEAR_EN
        clr_cnt_d = clr_cnt;
`endif
        case (state)
            IDLE: begin
                if (START) begin
                    mq_d   = m_clamped;
                    tq_d   = t_clamped;
                    r_d    = 4'd0;
                    c_d    = 3'd0;
                    pack_d = 64'd0;
`ifdef MACOUT_CLEAR_EN
                    // First clear write (address 0) issues on the START edge itself.
                    state_d   = CLEAR;
                    wr_d      = 1'b1;
                    addr_d    = 4'd0;
                    wdata_d   = 64'd0;
                    clr_cnt_d = 5'd1;
`else
                    state_d = (m_clamped == 4'd0 || t_clamped == 4'd0) ? FINISH : COLLECT;
`endif
                end
            end
`ifdef MACOUT_CLEAR_EN
            CLEAR: begin
                if (clr_cnt == 5'd16) begin
                    state_d = (mq == 4'd0 || tq == 4'd0) ? FINISH : COLLECT;
                end else begin
                    wr_d      = 1'b1;
                    addr_d    = clr_cnt[3:0];
                    wdata_d   = 64'd0;
                    clr_cnt_d = clr_cnt + 5'd1;
                end
            end
`endif
            COLLECT: begin
                if (accept) begin
                    if (word_done) begin
                        // Write data is registered on the accepting edge so it appears in WRITE.
                        state_d = WRITE;
                        wr_d    = 1'b1;
                        addr_d  = {r[2:0], c[2]};
                        wdata_d = merged;
                        pack_d  = 64'd0;
                    end else begin
                        pack_d = merged;
                        c_d    = c + 3'd1;
                    end
                end
            end
            WRITE: begin
                if (last_col) begin
                    c_d     = 3'd0;
                    r_d     = r + 4'd1;
                    state_d = last_row ? FINISH : COLLECT;
                end else begin
                    c_d     = c + 3'd1;
                    state_d = COLLECT;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            mq        <= 4'd0;
            tq        <= 4'd0;
            r         <= 4'd0;
            c         <= 3'd0;
            pack      <= 64'd0;
            RES_READY <= 1'b0;
            EN_O      <= 1'b0;
            RW_O      <= 1'b0;
            ADDR_O    <= 4'd0;
            WDATA_O   <= 64'd0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
`ifdef MACOUT_CLEAR_EN
            clr_cnt   <= 5'd0;
`endif
        end else begin
            state     <= state_d;
            mq        <= mq_d;
            tq        <= tq_d;
            r         <= r_d;
            c         <= c_d;
            pack      <= pack_d;
            RES_READY <= (state_d == COLLECT);
            EN_O      <= wr_d;
            RW_O      <= wr_d;
            ADDR_O    <= addr_d;
            WDATA_O   <= wdata_d;
            BUSY      <= (state_d != IDLE);
            DONE      <= (state_d == FINISH);
`ifdef MACOUT_CLEAR_EN
            clr_cnt   <= clr_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_macarray_out_writer.sv
// Self-checking bench for macarray_out_writer: table of directed jobs, hand-written corner sequences,
// and randomized jobs compared against a word-level model of the output SRAM writes.
module tb_macarray_out_writer;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [11:0] MNT = 12'd0;
    logic        START = 1'b0;
    logic        RES_VALID = 1'b0;
    logic [15:0] RES_DATA = 16'd0;
    logic        RES_READY, EN_O, RW_O, BUSY, DONE;
    logic [3:0]  ADDR_O;
    logic [63:0] WDATA_O;

    macarray_out_writer dut (
        .CLK(CLK), .RSTN(RSTN), .MNT(MNT), .START(START),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
        .EN_O(EN_O), .RW_O(RW_O), .ADDR_O(ADDR_O), .WDATA_O(WDATA_O),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

`ifdef MACOUT_CLEAR_EN
    localparam int OFF = 16;
    localparam int RDY_LAT = 17;
`else
    localparam int OFF = 0;
    localparam int RDY_LAT = 1;
`endif

    int nvec = 0;
    int nbad = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    logic [67:0] wq[$];
    logic [67:0] eq[$];
    logic [15:0] res[64];

    typedef struct {
        logic [11:0] mnt;
        logic [15:0] base;
        int          nwr;
        logic [67:0] first;
        logic [67:0] last;
    } vec_t;
    vec_t tbl[5];

    always @(posedge CLK) cyc <= cyc + 1;

    // Every write cycle is logged; RW_O must accompany EN_O and RES_READY must be low.
    always @(negedge CLK) begin
        if (RSTN && EN_O) begin
            wq.push_back({ADDR_O, WDATA_O});
            last_wr_cyc = cyc;
            nvec++;
            if (!RW_O || RES_READY) begin
                nbad++;
                $display("FAIL wr_ctl: rw=%0b ready=%0b, required rw=1 ready=0", RW_O, RES_READY);
            end
        end
    end

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic int clamp8(input logic [3:0] v);
        return (v > 4'd8) ? 8 : int'(v);
    endfunction

    // Reference: the list of SRAM writes a job must produce, built from the address map.
    task automatic build_expected(input int mq, input int tq);
        logic [63:0] d;
        int col;
        eq.delete();
        for (int a = 0; a < OFF; a++) eq.push_back({4'(a), 64'd0});
        for (int row = 0; row < mq; row++) begin
            for (int w = 0; w < (tq + 3) / 4; w++) begin
                d = 64'd0;
                for (int l = 0; l < 4; l++) begin
                    col = 4 * w + l;
                    if (col < tq) d[16*l +: 16] = res[row*tq + col];
                end
                eq.push_back({4'(2*row + w), d});
            end
        end
    endtask

    // mode 0: valid every cycle, 1: valid toggles 1,0,..., 2: random valid and random data.
    task automatic run_job(input logic [11:0] mnt, input int mode, input int base, input bit inject);
        int mq, tq, n, idx, k, first_rdy, done_cyc;
        bit acc, done_seen;
        mq = clamp8(mnt[11:8]);
        tq = clamp8(mnt[3:0]);
        n = mq * tq;
        for (int i = 0; i < n; i++) res[i] = (mode == 2) ? 16'($urandom) : 16'(base + i + 1);
        wq.delete();
        @(negedge CLK);
        MNT = mnt;
        START = 1'b1;
        RES_VALID = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        k = 1; idx = 0; first_rdy = -1; done_seen = 1'b0; done_cyc = 0;
        while (k < 400) begin
            if (RES_READY && first_rdy < 0) first_rdy = k;
            if (DONE) begin
                done_seen = 1'b1;
                done_cyc = cyc;
                break;
            end
            START = inject && (k == 3);
            case (mode)
                0: RES_VALID = 1'b1;
                1: RES_VALID = (k % 2 == 1);
                default: RES_VALID = 1'($urandom);
            endcase
            RES_DATA = (idx < n && RES_VALID) ? res[idx] : 16'($urandom);
            acc = RES_VALID && RES_READY;
            @(posedge CLK);
            if (acc && idx < n) idx++;
            @(negedge CLK);
            k++;
        end
        START = 1'b0;
        RES_VALID = 1'b0;
        if (!done_seen) begin
            nvec++;
            nbad++;
            $display("FAIL timeout: no DONE after %0d cycles, required DONE", k);
            return;
        end
        chk("busy_at_done", 68'(BUSY), 68'd1);
        chk("accepted", 68'(idx), 68'(n));
        if (n > 0) chk("ready_latency", 68'(first_rdy), 68'(RDY_LAT));
        else       chk("ready_never", 68'(first_rdy), 68'(-1));
        if (wq.size() > 0) chk("done_after_wr", 68'(done_cyc - last_wr_cyc), 68'd1);
        else               chk("done_latency", 68'(k), 68'd1);
        @(negedge CLK);
        chk("done_busy_after", 68'({DONE, BUSY}), 68'd0);
        build_expected(mq, tq);
        chk("wr_count", 68'(wq.size()), 68'(eq.size()));
        if (wq.size() == eq.size())
            for (int i = 0; i < eq.size(); i++) chk($sformatf("wr%0d", i), wq[i], eq[i]);
    endtask

    initial begin
        int okw;
        tbl[0] = '{12'h203, 16'h0000, 2, {4'd0, 64'h0000_0003_0002_0001}, {4'd2, 64'h0000_0006_0005_0004}};
        tbl[1] = '{12'h108, 16'h0010, 2, {4'd0, 64'h0014_0013_0012_0011}, {4'd1, 64'h0018_0017_0016_0015}};
        tbl[2] = '{12'hF4F, 16'h0100, 16, {4'd0, 64'h0104_0103_0102_0101}, {4'd15, 64'h0140_013F_013E_013D}};
        tbl[3] = '{12'h040, 16'h0000, 0, 68'd0, 68'd0};
        tbl[4] = '{12'h305, 16'h0200, 6, {4'd0, 64'h0204_0203_0202_0201}, {4'd5, 64'h0000_0000_0000_020F}};

        #1;
        chk("reset_ctl", 68'({RES_READY, EN_O, RW_O, BUSY, DONE}), 68'd0);
        chk("reset_addr", 68'(ADDR_O), 68'd0);
        chk("reset_wdata", 68'(WDATA_O), 68'd0);
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_job(tbl[v].mnt, 0, int'(tbl[v].base), 1'b0);
            chk($sformatf("tbl%0d_nwr", v), 68'(wq.size()), 68'(tbl[v].nwr + OFF));
            if (tbl[v].nwr > 0 && wq.size() == tbl[v].nwr + OFF) begin
                chk($sformatf("tbl%0d_first", v), wq[OFF], tbl[v].first);
                chk($sformatf("tbl%0d_last", v), wq[wq.size()-1], tbl[v].last);
            end
        end

        // Source stalls with a stray START in the middle of the job.
        run_job(12'h104, 1, 16'h0040, 1'b1);
        chk("stall_word", wq[wq.size()-1], {4'd0, 64'h0044_0043_0042_0041});
        @(negedge CLK);
        chk("stray_start_idle", 68'(BUSY), 68'd0);

        // Asynchronous reset after the first word of a job has been written.
        wq.delete();
        @(negedge CLK);
        MNT = 12'h203;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        RES_VALID = 1'b1;
        okw = 0;
        for (int i = 0; i < 40 && okw < 4; i++) begin
            RES_DATA = 16'(16'h0A0 + okw);
            if (RES_READY) begin
                @(posedge CLK);
                okw++;
            end else begin
                @(posedge CLK);
            end
            if (okw < 4) @(negedge CLK);
        end
        #2;
        chk("pre_reset_wdata_nonzero", 68'(WDATA_O != 64'd0), 68'd1);
        RSTN = 1'b0;
        #1;
        chk("async_rst_ctl", 68'({RES_READY, EN_O, RW_O, BUSY, DONE}), 68'd0);
        chk("async_rst_addr", 68'(ADDR_O), 68'd0);
        chk("async_rst_wdata", 68'(WDATA_O), 68'd0);
        RES_VALID = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        run_job(12'h203, 0, 16'h0300, 1'b0);

        for (int j = 0; j < 25; j++) begin
            logic [11:0] m;
            m = {4'($urandom_range(0, 10)), 4'($urandom), 4'($urandom_range(0, 10))};
            run_job(m, 2, 0, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
